// File: rtl/line_draw_stream.sv
// line_draw_stream: Bresenham line rasteriser.
// Accepts one two-endpoint command at a time and streams every pixel of the
// line over a valid/ready handshake, with abort and a last-pixel flag.
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   RUN   | emitting pixels; stalls while pix_ready is low
module line_draw_stream #(
    parameter int XW = 11,
    parameter int YW = 10,
    parameter int CW = ((XW > YW) ? XW : YW) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic          abort,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_last,
    output logic [CW-1:0] pix_count,
    output logic          busy,
    output logic          done
);
    // One bit of headroom over the widest coordinate plus a sign bit keeps
    // dx, dy and err exact for any endpoint pair.
    localparam int W = ((XW > YW) ? XW : YW) + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [XW-1:0]       x1_q;
    logic [YW-1:0]       y1_q;
    logic                right;
    logic                down;
    logic signed [W-1:0] dx;
    logic signed [W-1:0] dy;
    logic signed [W-1:0] err;

    logic signed [W-1:0] x0_e, x1_e, y0_e, y1_e;
    logic signed [W-1:0] dx_c, dy_c;
    logic signed [W:0]   e2, dx_w, dy_w;
    logic                step_x, step_y;
    logic signed [W-1:0] err_nxt;
    logic                handshake;

    // Command decode: zero-extended endpoints, |dx| and -|dy| for the new line.
    always_comb begin
        x0_e = $signed({{(W-XW){1'b0}}, x0});
        x1_e = $signed({{(W-XW){1'b0}}, x1});
        y0_e = $signed({{(W-YW){1'b0}}, y0});
        y1_e = $signed({{(W-YW){1'b0}}, y1});
        dx_c = (x1_e >= x0_e) ? (x1_e - x0_e) : (x0_e - x1_e);
        dy_c = (y1_e >= y0_e) ? (y0_e - y1_e) : (y1_e - y0_e);
    end

    // Bresenham step decision from the pre-update error; both axes may step.
    always_comb begin
        e2      = $signed({err, 1'b0});
        dx_w    = dx;
        dy_w    = dy;
        step_x  = (e2 > dy_w);
        step_y  = (e2 < dx_w);
        err_nxt = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    end

    assign handshake = pix_valid & pix_ready;
    assign pix_last  = pix_valid & (pix_x == x1_q) & (pix_y == y1_q);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);

    // Line FSM: command capture, per-pixel stepping, abort and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            x1_q      <= '0;
            y1_q      <= '0;
            right     <= 1'b0;
            down      <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_count <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is meaningless here, so a simultaneous command still goes through
                    if (cmd_valid) begin
                        x1_q      <= x1;
                        y1_q      <= y1;
                        right     <= (x1 >= x0);
                        down      <= (y1 >= y0);
                        dx        <= dx_c;
                        dy        <= dy_c;
                        err       <= dx_c + dy_c;
                        pix_x     <= x0;
                        pix_y     <= y0;
                        pix_count <= '0;
                        pix_valid <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // the pixel on the bus is dropped and not counted
                        pix_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (handshake) begin
                        pix_count <= pix_count + CW'(1);
                        if (pix_last) begin
                            pix_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            if (step_x)
                                pix_x <= right ? (pix_x + XW'(1)) : (pix_x - XW'(1));
                            if (step_y)
                                pix_y <= down ? (pix_y + YW'(1)) : (pix_y - YW'(1));
                            err <= err_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_draw_stream.sv
// Testbench for line_draw_stream: table of lines plus hand-written corner
// sequences; expected pixels come from a behavioural Bresenham model queue.
module tb_line_draw_stream;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [XW-1:0] cx0 = '0, cx1 = '0;
    logic [YW-1:0] cy0 = '0, cy1 = '0;
    logic          abort = 1'b0;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_last;
    logic [CW-1:0] pix_count;
    logic          busy;
    logic          done;

    line_draw_stream #(.XW(XW), .YW(YW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .x0(cx0), .x1(cx1), .y0(cy0), .y1(cy1),
        .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
        .pix_count(pix_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit last;
    } pix_t;

    typedef struct {
        int x0;
        int y0;
        int x1;
        int y1;
        int rmode;   // 0: pix_ready always 1, 1: alternating 1,0
        int cnt;     // expected pixels in the line
    } vec_t;

    pix_t exp_q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Textbook integer Bresenham producing the full pixel list of a line.
    function automatic void model_line(input int ax0, input int ay0, input int ax1, input int ay1);
        int mdx, mdy, sx, sy, merr, e2, x, y;
        pix_t p;
        mdx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        mdy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
        sx   = (ax1 >= ax0) ? 1 : -1;
        sy   = (ay1 >= ay0) ? 1 : -1;
        merr = mdx + mdy;
        x = ax0;
        y = ay0;
        for (int n = 0; n < 5000; n++) begin
            p.x = x;
            p.y = y;
            p.last = (x == ax1) && (y == ay1);
            exp_q.push_back(p);
            if (p.last) break;
            e2 = 2 * merr;
            if (e2 > mdy) begin merr += mdy; x += sx; end
            if (e2 < mdx) begin merr += mdx; y += sy; end
        end
    endfunction

    // Issue a command at a negedge; returns at the negedge after acceptance.
    task automatic send_cmd(input int ax0, input int ay0, input int ax1, input int ay1, input bit ab);
        chk("cmd_ready_idle", cmd_ready, 1);
        cx0 = XW'(ax0); cy0 = YW'(ay0); cx1 = XW'(ax1); cy1 = YW'(ay1);
        cmd_valid = 1'b1;
        abort = ab;
        model_line(ax0, ay0, ax1, ay1);
        @(negedge clk);
        cmd_valid = 1'b0;
        abort = 1'b0;
        chk("first_pixel", {pix_valid, busy, pix_x, pix_y}, {1'b1, 1'b1, XW'(ax0), YW'(ay0)});
    endtask

    // Consume pixels until done, checking each against the model and stall stability.
    task automatic drain(input int rmode, input int exp_cnt);
        int cyc = 0;
        bit ph = 1'b0;
        bit prev_stall = 1'b0;
        logic [XW-1:0] hx;
        logic [YW-1:0] hy;
        logic [CW-1:0] hc;
        logic          hl;
        pix_t e;
        while (done !== 1'b1 && cyc < 5000) begin
            if (prev_stall)
                chk("stall_hold", {pix_valid, pix_last, pix_x, pix_y, pix_count}, {1'b1, hl, hx, hy, hc});
            pix_ready = (rmode == 0) ? 1'b1 : ~ph;
            ph = ~ph;
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pixel", {pix_x, pix_y}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", {pix_last, pix_x, pix_y}, {e.last, XW'(e.x), YW'(e.y)});
                end
            end
            prev_stall = pix_valid && !pix_ready;
            hx = pix_x; hy = pix_y; hc = pix_count; hl = pix_last;
            @(negedge clk);
            cyc++;
        end
        pix_ready = 1'b1;
        chk("done_seen", done, 1);
        if (rmode == 0) chk("line_cycles", cyc, exp_cnt);
        chk("end_state", {pix_valid, pix_last, cmd_ready, busy}, {1'b0, 1'b0, 1'b1, 1'b0});
        chk("pix_count", pix_count, exp_cnt);
        chk("model_drained", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{0, 0, 4, 0, 0, 5};
        vecs[1] = '{10, 20, 7, 13, 0, 8};
        vecs[2] = '{0, 0, 3, 3, 1, 4};
        vecs[3] = '{20, 5, 3, 10, 1, 18};
        vecs[4] = '{3, 30, 8, 1, 0, 30};
        vecs[5] = '{50, 40, 41, 43, 1, 10};
        vecs[6] = '{0, 9, 7, 0, 0, 10};
        vecs[7] = '{0, 0, 2047, 1023, 0, 2048};

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("reset_vals", {pix_valid, pix_x, pix_y, pix_count, done, busy, pix_last, cmd_ready},
            {1'b0, XW'(0), YW'(0), CW'(0), 1'b0, 1'b0, 1'b0, 1'b1});
        reset_n = 1'b1;

        // table of lines across octants, with and without back-pressure
        for (int i = 0; i < 8; i++) begin
            send_cmd(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, 1'b0);
            drain(vecs[i].rmode, vecs[i].cnt);
            @(negedge clk);
        end

        // degenerate line followed by a command on the done cycle
        send_cmd(5, 5, 5, 5, 1'b0);
        chk("degen_last", pix_last, 1);
        drain(0, 1);
        send_cmd(0, 0, 1, 0, 1'b0);
        drain(0, 2);
        @(negedge clk);

        // abort mid-line; abort together with a command in IDLE is ignored
        send_cmd(0, 0, 100, 0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("abort_pre_pixel", {pix_valid, pix_x, pix_y}, {1'b1, XW'(i), YW'(0)});
            @(negedge clk);
        end
        chk("abort_at_pixel", {pix_valid, pix_x}, {1'b1, XW'(2)});
        pix_ready = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_after", {pix_valid, done, cmd_ready, busy, pix_count}, {1'b0, 1'b0, 1'b1, 1'b0, CW'(2)});
        @(negedge clk);
        chk("abort_no_done", {done, pix_count}, {1'b0, CW'(2)});
        exp_q.delete();
        send_cmd(7, 3, 9, 3, 1'b0);
        drain(0, 3);
        @(negedge clk);

        // asynchronous reset in the middle of a full-range line
        send_cmd(0, 0, 2047, 1023, 1'b0);
        for (int i = 0; i < 300; i++) @(negedge clk);
        chk("mid_line_busy", {busy, pix_valid}, {1'b1, 1'b1});
        reset_n = 1'b0;
        #1;
        chk("async_reset", {pix_valid, pix_x, pix_y, pix_count, done, busy, pix_last, cmd_ready},
            {1'b0, XW'(0), YW'(0), CW'(0), 1'b0, 1'b0, 1'b0, 1'b1});
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        send_cmd(1, 1, 4, 2, 1'b0);
        drain(0, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_draw_stream.md
# line_draw_stream

Parametrised Bresenham line rasteriser with handshaked command input and a back-pressurable pixel stream. Accepts one line command (two endpoints) at a time and emits every pixel of the line, one per cycle when the consumer is ready, in any of the eight octants. Sits between the shape/command sequencer and the frame-buffer write port. Unlike the previous free-running line drawer it adds:

- parametrised coordinate widths;
- stall on consumer back-pressure;
- abort;
- an explicit last-pixel flag.

## Interface
Parameters:
- XW, 11, x coordinate width (unsigned)
- YW, 10, y coordinate width (unsigned)
- CW, derived = max(XW,YW)+1, pixel counter width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- cmd_valid  in  1  command present on x0/y0/x1/y1
- cmd_ready  out  1  block can accept a command (= state IDLE)
- x0, x1  in  XW  start / end x
- y0, y1  in  YW  start / end y
- abort  in  1  terminate current line (RUN only)
- pix_valid  out  1  pix_x/pix_y hold a valid pixel
- pix_ready  in  1  consumer accepts pixel this cycle
- pix_x  out  XW  current pixel x
- pix_y  out  YW  current pixel y
- pix_last  out  1  current pixel is the end point; 0 when pix_valid=0
- pix_count  out  CW  pixels handshaked so far for the current line
- busy  out  1  state RUN
- done  out  1  one-cycle pulse after the last pixel is handshaked

## Operation
- States: IDLE, RUN. Reset → IDLE.
- Reset values: pix_valid=0, pix_x=0, pix_y=0, pix_count=0, done=0, busy=0, pix_last=0, cmd_ready=1.
- Internal arithmetic: signed width W = max(XW,YW)+2 for dx, dy, err. Doubled error term e2 = err<<1 has width W+1. Endpoints are zero-extended before subtraction.
- IDLE, on cmd_valid & cmd_ready:
  - latch x1, y1;
  - dx = |x1-x0|, right = (x1>=x0);
  - dy = -|y1-y0|, down = (y1>=y0);
  - err = dx+dy;
  - pix_x=x0, pix_y=y0, pix_count=0, pix_valid=1;
  - go to RUN.
- RUN, pixel handshake (pix_valid & pix_ready):
  - pix_count increments.
  - If pix_last: pix_valid=0, done=1 next cycle, go to IDLE.
  - Otherwise step using the pre-update err and e2:
    - if e2>dy: x±1 (+ if right), err += dy;
    - if e2<dx: y±1 (+ if down), err += dx;
    - both steps may occur in the same cycle (diagonal); the two err contributions sum.
- RUN with pix_ready=0: pix_x, pix_y, pix_valid, pix_last, err and pix_count hold unchanged.
- Abort:
  - abort=1 in RUN has priority over a simultaneous handshake. The pixel is not counted.
  - Next cycle: IDLE, pix_valid=0, done stays 0, pix_count holds its value.
  - abort in IDLE is ignored. abort together with cmd_valid in IDLE: the command is accepted.
- pix_last = pix_valid & (pix_x==x1) & (pix_y==y1).
- Total pixels per line = max(|x1-x0|,|y1-y0|)+1, never more than 2^(CW-1). pix_count does not wrap.
- Degenerate line (x0==x1, y0==y1): exactly one pixel with pix_last=1.
- cmd_valid in RUN is not accepted; it must be held by the producer.

## Timing
- Command accepted at edge N → first pixel valid after edge N (cycle N+1).
- With pix_ready held at 1: one pixel per cycle; a line of P pixels occupies P cycles of pix_valid.
- Last-pixel handshake at edge M → done=1, cmd_ready=1, pix_valid=0 during cycle M+1.
- Back-to-back: a command accepted at edge M+1 puts its first pixel out in cycle M+2. One bubble cycle between lines.
- Abort sampled at edge A → pix_valid=0, cmd_ready=1 from cycle A+1.
- reset_n low at any time: all outputs take their reset values immediately (asynchronous). The line in progress is discarded. First command is accepted on the first edge with reset_n high.

## Test plan
- Horizontal line (0,0)→(4,0), pix_ready=1 → pixels x=0..4, y=0 on 5 consecutive cycles; pix_last only on (4,0); done 1 cycle later; pix_count=5.
- Steep reverse line (10,20)→(7,13), pix_ready=1 → 8 pixels, x non-increasing, y decreasing by 1 each pixel; ends at (7,13); pix_count=8.
- Diagonal (0,0)→(3,3) with pix_ready alternating 1,0 → pixels (0,0),(1,1),(2,2),(3,3); outputs stable in every pix_ready=0 cycle; done after (3,3).
- Degenerate (5,5)→(5,5) immediately followed by (0,0)→(1,0) → one pixel with pix_last=1, done; second command accepted on the done cycle; next pixels (0,0),(1,0).
- (0,0)→(100,0) with abort on the cycle showing (2,0) → pix_valid=0 next cycle, done never asserted, pix_count=2, cmd_ready=1; a new command is accepted next.
- Full-range (0,0)→(2047,1023) at default params, with reset_n pulsed low for one cycle mid-line on a second run:
  - first run: 2048 pixels, pix_count=2048, last pixel (2047,1023);
  - second run: all outputs return to reset values asynchronously.
